seq_top: RTL and testbench
==========================

Name: seq_top

Overview:
- Bit-serial adder, LSB first. Each clock consumes one bit of each operand (A, B) and produces one sum bit (Z).
- A single carry flip-flop holds the carry between bit positions.
- Used as a leaf arithmetic block wherever two serial bit streams are summed.
- Optional word framing clears the carry automatically after a fixed number of bits.

Parameters:
- WORD_BITS, default 0: operand width in bits. 0 means unframed: the carry is never auto-cleared. N ≥ 1 means the carry is forced to 0 after every N consumed bits.
- CNT_W, default 8: width of the internal bit counter. Must satisfy 2**CNT_W ≥ WORD_BITS.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  operand A serial bit, LSB first.
- B  input  1  operand B serial bit, LSB first.
- Z  output  1  serial sum bit (Mealy, combinational from A, B and the carry).
- Positional instantiation order used by existing benches: A, B, clk, Z, rst_n.

Behaviour:
- State is carry (1 bit) plus bit_cnt (CNT_W bits). bit_cnt exists only when WORD_BITS > 0.
- Reset:
  - rst_n low asynchronously forces carry = 0 and bit_cnt = 0, immediately and independent of clk.
  - Reset is held while rst_n is low. State updates resume on the first rising clk edge after rst_n goes high.
- Output Z:
  - Z = A ^ B ^ carry at all times, combinational, with no latency.
  - During reset, Z = A ^ B.
- Carry update on each rising clk edge while rst_n is high:
  - Compute next_carry = (A & B) | (carry & (A | B)).
  - If WORD_BITS == 0: carry <= next_carry.
  - If WORD_BITS > 0 and bit_cnt == WORD_BITS-1 (last bit of the word): carry <= 0 and bit_cnt <= 0. The final carry-out is discarded, i.e. modulo 2**WORD_BITS.
  - Otherwise: carry <= next_carry and bit_cnt <= bit_cnt + 1.
- Z on the last bit of a word still uses the incoming carry. Only the stored carry is cleared.
- No handshake: every rising edge out of reset consumes one bit pair. Inputs must be stable in a setup window around the rising edge.
- Reset mid-word: the carry and bit_cnt are lost and the next bit is treated as an LSB.
- WORD_BITS == 1: carry is cleared every cycle, so Z = A ^ B permanently.
- No X propagation: carry always has a defined value after reset.

Decomposition:
- Shared package seq_pkg holds the constant CARRY_RST = 1'b0 and a function carry_next(a, b, c) reused by the datapath and by the bench model.
- One natural sub-module: full_adder_1b (inputs a, b, cin; outputs s, cout), instantiated once.
- seq_top contains only the carry register, the bit counter and the framing logic.

Test Plan:
- Async reset: with A=1, B=1 and carry=1, drop rst_n between clock edges -> carry=0 immediately and Z=0 (1^1^0) before the next edge.
- Unframed trace, WORD_BITS=0, after reset. Apply {A,B} per clock = 00, 11, 01, 11, 10, 01, 10:
  - Required Z before each edge = 0, 0, 0, 1, 0, 0, 0.
  - Required carry after each edge = 0, 1, 1, 1, 1, 1, 1.
- Carry chain: after reset, apply A=1, B=1 for 1 cycle, then A=1, B=0 for 4 cycles -> Z = 0, 0, 0, 0, 0 and carry stays 1. Then apply 00 -> Z=1 and carry -> 0.
- Word framing, WORD_BITS=4: add 0xF + 0x1 (LSB first) -> Z stream 0, 0, 0, 0 and carry = 0 at the start of the next word. Next word 0x3 + 0x5 -> Z stream 0, 0, 0, 1 (= 0x8).
- Reset mid-word, WORD_BITS=4: after 2 bits of 11, 11 (carry=1, bit_cnt=2), pulse rst_n -> bit_cnt=0 and carry=0. The next 4 bits are summed as a fresh word.
- Random check: 1000 random 16-bit operand pairs with WORD_BITS=16 -> serial Z word equals (A+B) mod 2**16, compared against a reference model using carry_next.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and carry helper for the bit-serial adder.
// Used by the datapath and by the bench reference model.
package seq_pkg;

   localparam logic CARRY_RST = 1'b0;

   function automatic logic carry_next(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (c & (a | b));
   endfunction

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder.
// Ports: a, b, cin in; s (sum), cout (carry out) out.
module full_adder_1b
   import seq_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = carry_next(a, b, cin);

endmodule

// File: rtl/seq_top.sv
// Bit-serial LSB-first adder with optional word framing.
// Ports: A, B serial operands; clk; Z serial sum (Mealy); rst_n async low.
module seq_top
   import seq_pkg::*;
#(
   parameter int WORD_BITS = 0,
   parameter int CNT_W     = 8
) (
   input  logic A,
   input  logic B,
   input  logic clk,
   output logic Z,
   input  logic rst_n
);

   logic carry;
   logic cout;
   logic last;

   full_adder_1b u_fa (
      .a    (A),
      .b    (B),
      .cin  (carry),
      .s    (Z),
      .cout (cout)
   );

   // Counter only exists when framing is enabled; the carry-out of the
   // last bit of a word is dropped so each word sums modulo 2**WORD_BITS.
   generate
      if (WORD_BITS > 0) begin : g_frame
         logic [CNT_W-1:0] bit_cnt;

         assign last = (bit_cnt == CNT_W'(WORD_BITS - 1));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bit_cnt <= '0;
            end else if (last) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end else begin : g_free
         assign last = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry <= CARRY_RST;
      end else if (last) begin
         carry <= CARRY_RST;
      end else begin
         carry <= cout;
      end
   end

endmodule

// File: tb/tb_seq_top.sv
// Scoreboard bench for seq_top: unframed, 4-bit and 16-bit framed instances.
// Stimulus pushes expected Z; a monitor pops and compares each cycle.
module tb_seq_top;
   import seq_pkg::*;

   typedef struct {
      int   inst;
      logic z;
      int   ph;
   } exp_t;

   logic clk;
   logic rst_n;
   logic A;
   logic B;
   logic z0;
   logic z4;
   logic z16;

   exp_t q[$];
   int   checks;
   int   failures;

   seq_top #(.WORD_BITS(0)) u0 (
      .A(A), .B(B), .clk(clk), .Z(z0), .rst_n(rst_n)
   );

   seq_top #(.WORD_BITS(4)) u4 (
      .A(A), .B(B), .clk(clk), .Z(z4), .rst_n(rst_n)
   );

   seq_top #(.WORD_BITS(16)) u16 (
      .A(A), .B(B), .clk(clk), .Z(z16), .rst_n(rst_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: sample Z mid low phase, well away from the rising edge.
   initial begin
      exp_t e;
      logic act;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            act = (e.inst == 0) ? z0 : (e.inst == 1) ? z4 : z16;
            checks++;
            if (act !== e.z) begin
               failures++;
               $display("FAIL ph%0d inst%0d z got=%b exp=%b t=%0t",
                        e.ph, e.inst, act, e.z, $time);
            end
         end
      end
   end

   task automatic push(input int inst, input logic ez, input int ph);
      exp_t e;
      e.inst = inst;
      e.z    = ez;
      e.ph   = ph;
      q.push_back(e);
   endtask

   task automatic step(input logic a, input logic b, input logic ez,
                       input int inst, input int ph);
      @(negedge clk);
      A = a;
      B = b;
      push(inst, ez, ph);
   endtask

   // Reset released just after a rising edge so the next edge takes an LSB.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      A = 1'b0;
      B = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic word(input int inst, input int n, input logic [15:0] a,
                       input logic [15:0] b, input int ph);
      logic [16:0] s;
      s = 17'(a) + 17'(b);
      for (int i = 0; i < n; i++) begin
         step(a[i], b[i], s[i], inst, ph);
      end
   endtask

   logic [1:0] tr_ab [7];
   logic       tr_z  [7];
   logic       mc;
   logic       ra;
   logic       rb;
   logic [15:0] wa;
   logic [15:0] wb;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      A        = 1'b0;
      B        = 1'b0;

      tr_ab = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10};
      tr_z  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state: Z = A ^ B while held in reset.
      @(negedge clk);
      A = 1'b1;
      B = 1'b0;
      push(0, 1'b1, 0);
      @(negedge clk);
      A = 1'b1;
      B = 1'b1;
      push(0, 1'b0, 0);

      // Asynchronous reset between edges with carry = 1.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 0, 1);
      step(1'b1, 1'b1, 1'b1, 0, 1);
      @(negedge clk);
      A = 1'b1;
      B = 1'b1;
      rst_n = 1'b0;
      push(0, 1'b0, 1);
      step(1'b1, 1'b1, 1'b0, 0, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 0, 1);
      step(1'b0, 1'b0, 1'b1, 0, 1);

      // Unframed trace, then one 00 to expose the final carry.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(tr_ab[i][1], tr_ab[i][0], tr_z[i], 0, 2);
      end
      step(1'b0, 1'b0, 1'b1, 0, 2);

      // Carry chain.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 0, 3);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 0, 3);
      end
      step(1'b0, 1'b0, 1'b1, 0, 3);
      step(1'b0, 1'b0, 1'b0, 0, 3);

      // Unframed random stream against carry_next model.
      do_reset();
      mc = CARRY_RST;
      for (int i = 0; i < 200; i++) begin
         ra = 1'($urandom);
         rb = 1'($urandom);
         step(ra, rb, ra ^ rb ^ mc, 0, 4);
         mc = carry_next(ra, rb, mc);
      end

      // 4-bit framing: carry-out dropped, next word starts clean.
      do_reset();
      word(1, 4, 16'hF, 16'h1, 5);
      word(1, 4, 16'h3, 16'h5, 5);
      word(1, 4, 16'hF, 16'hF, 5);
      word(1, 4, 16'h0, 16'h0, 5);

      // Reset mid-word: counter and carry lost, next bit is an LSB.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1, 6);
      step(1'b1, 1'b1, 1'b1, 1, 6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      word(1, 4, 16'h7, 16'h1, 6);
      word(1, 4, 16'hF, 16'h1, 6);
      word(1, 4, 16'h6, 16'h7, 6);

      // 16-bit framed random words plus boundary words.
      do_reset();
      word(2, 16, 16'hFFFF, 16'h0001, 7);
      word(2, 16, 16'hFFFF, 16'hFFFF, 7);
      word(2, 16, 16'h8000, 16'h8000, 7);
      for (int i = 0; i < 1000; i++) begin
         wa = 16'($urandom);
         wb = 16'($urandom);
         word(2, 16, wa, wb, 8);
      end

      repeat (3) @(negedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
